// File: rtl/sync_input_receiver.sv
// Receive side for the fg_opto pulse and the wire sensor: synchronizes both inputs,
// measures fg_opto period/high width, detects fg_opto loss and debounces the wire sensor.
// Optional macro SYNC_INPUT_RECEIVER_GLITCH_CNT_EN adds the glitch_cnt rejected-bounce counter.
module sync_input_receiver #(
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES  = 200000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fg_opto_in,
  input  logic             wire_sensor_in,
  output logic             fg_rise,
  output logic [CNT_W-1:0] fg_period,
  output logic [CNT_W-1:0] fg_width,
  output logic             meas_valid,
  output logic             fg_lost,
  output logic             wire_stable,
`ifdef SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
  output logic [15:0]      glitch_cnt,
`endif
  output logic             wire_rise
);

  localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LOST} state_t;

  logic fg_s1_q, fg_s2_q, fg_s3_q, fg_rise_q, fg_fall_q;
  logic w_s1_q, w_s2_q;
  logic [CNT_W-1:0] pcnt_q, hcnt_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d, width_q, width_d, width_tmp_q, width_tmp_d;
  logic             meas_valid_q, meas_valid_d, lost_q, lost_d;

  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              stable_q, stable_d, stable_prev_q, wire_rise_q;

  // Two-flop synchronizers; fg gets a third stage for registered edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      fg_s1_q   <= 1'b0;
      fg_s2_q   <= 1'b0;
      fg_s3_q   <= 1'b0;
      fg_rise_q <= 1'b0;
      fg_fall_q <= 1'b0;
      w_s1_q    <= 1'b0;
      w_s2_q    <= 1'b0;
    end else begin
      fg_s1_q   <= fg_opto_in;
      fg_s2_q   <= fg_s1_q;
      fg_s3_q   <= fg_s2_q;
      fg_rise_q <= fg_s2_q & ~fg_s3_q;
      fg_fall_q <= ~fg_s2_q & fg_s3_q;
      w_s1_q    <= wire_sensor_in;
      w_s2_q    <= w_s1_q;
    end
  end

  // Saturating period counter and high-width counter, both restarted by a rise
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      if (fg_rise_q)             pcnt_q <= CNT_W'(1);
      else if (pcnt_q != CNT_MAX) pcnt_q <= pcnt_q + CNT_W'(1);
      if (fg_rise_q)                        hcnt_q <= CNT_W'(1);
      else if (fg_s3_q && hcnt_q != CNT_MAX) hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      width_q      <= '0;
      width_tmp_q  <= '0;
      meas_valid_q <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      width_q      <= width_d;
      width_tmp_q  <= width_tmp_d;
      meas_valid_q <= meas_valid_d;
      lost_q       <= lost_d;
    end
  end

  // Timeout beats a coincident fall in HIGH; a rise beats the timeout in LOW
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    width_d      = width_q;
    width_tmp_d  = width_tmp_q;
    meas_valid_d = 1'b0;
    lost_d       = lost_q;
    case (state_q)
      IDLE: if (fg_rise_q) state_d = HIGH;
      HIGH: begin
        if (pcnt_q >= TIMEOUT) begin
          state_d = LOST;
          lost_d  = 1'b1;
        end else if (fg_fall_q) begin
          width_tmp_d = hcnt_q;
          state_d     = LOW;
        end
      end
      LOW: begin
        if (fg_rise_q) begin
          period_d     = pcnt_q;
          width_d      = width_tmp_q;
          meas_valid_d = 1'b1;
          state_d      = HIGH;
        end else if (pcnt_q >= TIMEOUT) begin
          state_d = LOST;
          lost_d  = 1'b1;
        end
      end
      LOST: begin
        if (fg_rise_q) begin
          lost_d  = 1'b0;
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce: accept a change only after it has held for DEBOUNCE_CYCLES cycles
  always_comb begin
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    if (w_s2_q == stable_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DEB_LAST) begin
      dcnt_d   = '0;
      stable_d = ~stable_q;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q        <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      wire_rise_q   <= 1'b0;
    end else begin
      dcnt_q        <= dcnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      wire_rise_q   <= stable_q & ~stable_prev_q;
    end
  end

`ifdef SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
  logic        bounce_rej_c;
  logic [15:0] glitch_q;

  // A bounce is rejected when the counter was running and the input fell back
  assign bounce_rej_c = (w_s2_q == stable_q) && (dcnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset)                                  glitch_q <= '0;
    else if (bounce_rej_c && glitch_q != 16'hFFFF) glitch_q <= glitch_q + 16'd1;
  end

  assign glitch_cnt = glitch_q;
`endif

  assign fg_rise     = fg_rise_q;
  assign fg_period   = period_q;
  assign fg_width    = width_q;
  assign meas_valid  = meas_valid_q;
  assign fg_lost     = lost_q;
  assign wire_stable = stable_q;
  assign wire_rise   = wire_rise_q;

endmodule

// File: tb/tb_sync_input_receiver.sv
// Scoreboard bench for sync_input_receiver: a timestamp-based model derives the expected
// strobes and measurements from the driven inputs; a negedge monitor compares them.
module tb_sync_input_receiver;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEB_CYC = 20;
  localparam int unsigned TMO     = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fg_in = 1'b0;
  logic w_in = 1'b0;
  logic fg_rise, meas_valid, fg_lost, wire_stable, wire_rise;
  logic [CNT_W-1:0] fg_period, fg_width;
`ifdef SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  sync_input_receiver #(
    .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEB_CYC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .fg_opto_in(fg_in), .wire_sensor_in(w_in),
    .fg_rise(fg_rise), .fg_period(fg_period), .fg_width(fg_width),
    .meas_valid(meas_valid), .fg_lost(fg_lost), .wire_stable(wire_stable),
`ifdef SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt),
`endif
    .wire_rise(wire_rise)
  );

  typedef struct {
    int unsigned t;
    int unsigned per;
    int unsigned wid;
  } meas_t;

  meas_t       meas_q[$];
  int unsigned frise_q[$];
  int unsigned wrise_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // Model state: input histories (index = edges ago), rise/fall timestamps, expected levels
  bit          fh[0:4];
  bit          wh[0:3];
  bit          have_prev = 1'b0;
  int unsigned last_r = 0, wid_m = 0, last_chg = 0, glitch_m = 0;
  int unsigned per_out = 0, wid_out = 0;
  bit          lost_m = 1'b0, stable_m = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Behavioural reference: input events delayed by the synchronizer, rules applied on timestamps
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 5; i++) fh[i] = 1'b0;
      for (int i = 0; i < 4; i++) wh[i] = 1'b0;
      have_prev = 1'b0; lost_m = 1'b0; stable_m = 1'b0;
      per_out = 0; wid_out = 0; wid_m = 0; glitch_m = 0; last_chg = cyc;
      meas_q.delete(); frise_q.delete(); wrise_q.delete();
    end else begin
      for (int i = 4; i > 0; i--) fh[i] = fh[i-1];
      fh[0] = fg_in;
      for (int i = 3; i > 0; i--) wh[i] = wh[i-1];
      wh[0] = w_in;
      if (fh[2] && !fh[3]) frise_q.push_back(cyc);
      if (fh[3] && !fh[4]) begin
        if (have_prev && (cyc - last_r) <= TMO) begin
          meas_t m;
          m.t = cyc; m.per = cyc - last_r; m.wid = wid_m;
          meas_q.push_back(m);
          per_out = m.per; wid_out = m.wid;
        end
        lost_m = 1'b0; have_prev = 1'b1; last_r = cyc;
      end else if (have_prev && (cyc - last_r) >= TMO) begin
        lost_m = 1'b1;
      end
      if (!fh[3] && fh[4] && have_prev) wid_m = cyc - last_r;
      if (wh[2] != wh[3]) last_chg = cyc;
      if (wh[2] == stable_m && wh[3] != stable_m && glitch_m != 65535) glitch_m++;
      if (wh[2] != stable_m && (cyc - last_chg) == DEB_CYC - 1) begin
        stable_m = ~stable_m;
        if (stable_m) wrise_q.push_back(cyc + 1);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes or an expectation falls due
  always @(negedge clk) begin
    bit e;
    e = (frise_q.size() > 0) && (frise_q[0] == cyc);
    if (e || fg_rise) begin
      if (e) void'(frise_q.pop_front());
      check("fg_rise", longint'(fg_rise), longint'(e));
    end
    e = (wrise_q.size() > 0) && (wrise_q[0] == cyc);
    if (e || wire_rise) begin
      if (e) void'(wrise_q.pop_front());
      check("wire_rise", longint'(wire_rise), longint'(e));
    end
    e = (meas_q.size() > 0) && (meas_q[0].t == cyc);
    if (e || meas_valid) begin
      check("meas_valid", longint'(meas_valid), longint'(e));
      if (e) begin
        meas_t m;
        m = meas_q.pop_front();
        check("meas_period", longint'(fg_period), longint'(m.per));
        check("meas_width", longint'(fg_width), longint'(m.wid));
      end
    end
    check("fg_lost", longint'(fg_lost), longint'(lost_m));
    check("wire_stable", longint'(wire_stable), longint'(stable_m));
    check("held_period", longint'(fg_period), longint'(per_out));
    check("held_width", longint'(fg_width), longint'(wid_out));
`ifdef SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
    check("glitch_cnt", longint'(glitch_cnt), longint'(glitch_m));
`endif
  end

  task automatic pulse(input int unsigned per, input int unsigned hi);
    fg_in = 1'b1;
    repeat (hi) @(negedge clk);
    fg_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic wire_seq();
    w_in = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      w_in = ~w_in;
      repeat ($urandom_range(10, 1)) @(negedge clk);
    end
    w_in = 1'b1;
    repeat (200) @(negedge clk);
    w_in = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: simulation did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fg_in = 1'b1; w_in = 1'b1; reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    fg_in = 1'b0;
    repeat (30) @(negedge clk);

    // Steady pulses (fixed then random) alongside a bouncy wire sensor
    fork
      begin
        for (int i = 0; i < 4; i++) pulse(100, 30);
        for (int i = 0; i < 8; i++) begin
          int unsigned p;
          p = $urandom_range(250, 20);
          pulse(p, $urandom_range(p - 3, 3));
        end
      end
      wire_seq();
    join

    // Loss of fg_opto and recovery
    pulse(100, 30);
    repeat (TMO + 60) @(negedge clk);
    for (int i = 0; i < 5; i++) pulse(100, 30);

    // One-cycle reset in the middle of a high phase
    fg_in = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    fg_in = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(100, 40);

    // Periods at and around the timeout threshold
    pulse(TMO, 50);
    pulse(TMO, 50);
    pulse(TMO + 1, 50);
    pulse(100, 30);
    pulse(TMO - 1, 10);
    pulse(100, 30);
    repeat (30) @(negedge clk);

    check("fg_rise_queue_left", longint'(frise_q.size()), 0);
    check("meas_queue_left", longint'(meas_q.size()), 0);
    check("wire_rise_queue_left", longint'(wrise_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_input_receiver.md
Name: sync_input_receiver

Overview:
- Synthesizable receive side for the synchronization block's external timing inputs: frame-grabber opto pulse (fg_opto) and wire sensor.
- Synchronizes both asynchronous inputs, measures fg_opto period and open (high) width in clock cycles, detects fg_opto loss, and debounces the bouncy wire sensor into a clean level plus a rising-edge strobe.
- Sits between the board inputs and the main sync FSM, which consumes its strobes and measurements.

Parameters:
- CNT_W, 24, width of the period/width counters and outputs.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a wire_sensor change (10 us at 100 MHz).
- TIMEOUT_CYCLES, 200000, cycles without an fg_opto rising edge before fg_lost is raised. Must be < 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fg_opto_in  in  1  asynchronous frame-grabber opto pulse
- wire_sensor_in  in  1  asynchronous, bouncy wire sensor
- fg_rise  out  1  one-cycle strobe on synchronized fg_opto rising edge
- fg_period  out  CNT_W  last measured rise-to-rise period, cycles
- fg_width  out  CNT_W  last measured high width, cycles
- meas_valid  out  1  one-cycle strobe: fg_period/fg_width updated as a consistent pair
- fg_lost  out  1  level: no fg_opto rising edge for TIMEOUT_CYCLES
- wire_stable  out  1  debounced wire sensor level
- wire_rise  out  1  one-cycle strobe on wire_stable 0->1

Behaviour:
- Reset (clk edge with reset=1): every output 0; synchronizer flops 0; counters 0; FSM IDLE. Reset has priority over all events, including mid-measurement; partial measurements are discarded.
- Synchronization: two-flop synchronizer per input, then one registered edge-detect stage. fg_rise asserts 3 clock edges after the first edge that samples fg_opto_in high.
- Counter pcnt: loaded with 1 on the rise cycle, otherwise increments, saturating at 2^CNT_W-1. For rises P cycles apart, pcnt = P on the second rise.
- Counter hcnt: loaded with 1 on the rise cycle; increments while synchronized fg is high; frozen while low.
- FSM states: IDLE, HIGH, LOW, LOST.
  - IDLE: waits for first rise -> HIGH. No meas_valid is produced.
  - HIGH: on fall, latch width_tmp = hcnt -> LOW.
  - LOW: on rise, fg_period <= pcnt, fg_width <= width_tmp, meas_valid=1 for that cycle -> HIGH.
  - HIGH or LOW: if pcnt reaches TIMEOUT_CYCLES -> LOST, fg_lost=1.
  - LOST: on rise, fg_lost <= 0 in the same cycle -> HIGH. No meas_valid; the next valid pair comes on the following rise.
- Outputs fg_period/fg_width hold their values between meas_valid pulses, including through LOST.
- Rise on the same cycle as the timeout threshold: the rise wins; the measurement is reported and no LOST is entered.
- Debounce: counter dcnt clears whenever synchronized wire equals wire_stable; otherwise it increments. When dcnt reaches DEBOUNCE_CYCLES-1, wire_stable toggles and dcnt clears. A change is therefore accepted DEBOUNCE_CYCLES cycles after the synchronized input last settled.
- wire_rise: registered strobe, asserted the cycle after wire_stable goes 0->1.
- Pulses shorter than 2 clock periods may be missed by the synchronizer; this is accepted behaviour.

Optional Feature:
- Macro: SYNC_INPUT_RECEIVER_GLITCH_CNT_EN
- Defined: adds output port glitch_cnt (16 bits, reset 0). It increments, saturating at 0xFFFF, each time dcnt is cleared from a non-zero value without wire_stable toggling (a rejected bounce).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Assert reset 5 cycles with fg_opto_in=1 and wire_sensor_in=1 -> all outputs 0 during reset; after release, fg_rise fires once and no meas_valid.
- 100 MHz clk; fg_opto period 1 ms, high 300 us, 4 periods -> meas_valid on rises 2-4 with fg_period=100000 and fg_width=30000 each; fg_lost stays 0.
- wire_sensor: 5 us low, then 10 toggles of 10-100 ns each, held high 1 ms, then low -> exactly one wire_rise, 1000 cycles (+sync/register latency) after the last toggle. wire_stable falls 1000 cycles after the final drop. With the macro, glitch_cnt equals the number of rejected bounces.
- Stop fg_opto after a valid period -> fg_lost=1 exactly TIMEOUT_CYCLES after the last rise; resume 1 ms pulses -> fg_lost clears on the first rise, meas_valid only from the second rise; fg_period/fg_width held meanwhile.
- Assert reset for 1 cycle in the middle of an fg high phase -> outputs 0, FSM IDLE; the first meas_valid comes on the second full rise after reset.
- Rise coincident with pcnt=TIMEOUT_CYCLES (period = TIMEOUT_CYCLES) -> meas_valid with fg_period=200000; fg_lost never asserts.
